panda_if_stage: RTL

PANDA_IF_STAGE -- requirements
Module: panda_if_stage

---
 rtl/panda_if_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/panda_if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM, 1-entry skid buffer and IF/ID register.
// Optional macro PANDA_IF_MISALIGNED_TRAP_EN adds the registered instr_addr_misaligned_o flag.
package panda_pkg;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_inc;
    } if_id_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam if_id_t      IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_inc: 32'h0};
endpackage

module panda_if_stage #(
    parameter logic [31:0] BootAddr = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [31:0]       branch_target_i,
    output logic              instr_req_o,
    output logic [31:0]       instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [31:0]       instr_rdata_i,
    output panda_pkg::if_id_t if_id_o
`ifdef PANDA_IF_MISALIGNED_TRAP_EN
    ,
    output logic              instr_addr_misaligned_o
`endif
);
    import panda_pkg::*;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_e;

    state_e      state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] txn_addr_reg;
    logic        skid_valid_reg;
    logic [31:0] skid_instr_reg;
    logic [31:0] skid_pc_reg;
    if_id_t      if_id_reg;

    logic [31:0] target_aligned;
    logic        skid_block;
    logic        grant;
    logic        resp_take;

    // Masking keeps every target bit referenced; the low bits only matter to the trap flag.
    assign target_aligned = branch_target_i & 32'hFFFF_FFFC;
    assign skid_block     = skid_valid_reg && stall_i;
    assign instr_req_o    = (state_reg == S_REQ) && !skid_block;
    assign instr_addr_o   = fetch_pc_reg;
    assign grant          = instr_req_o && instr_gnt_i;
    // Only a response to a live (non-flushed) transaction reaches the pipeline.
    assign resp_take      = instr_rvalid_i && (state_reg == S_WAIT) && !flush_i;
    assign if_id_o        = if_id_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= S_REQ;
            fetch_pc_reg   <= BootAddr;
            txn_addr_reg   <= BootAddr;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= 32'h0;
            if_id_reg      <= IF_ID_BUBBLE;
        end else begin
            unique case (state_reg)
                S_REQ: begin
                    if (grant) begin
                        txn_addr_reg <= fetch_pc_reg;
                        state_reg    <= flush_i ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (instr_rvalid_i) begin
                        state_reg <= S_REQ;
                    end else if (flush_i) begin
                        state_reg <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (instr_rvalid_i) begin
                        state_reg <= S_REQ;
                    end
                end
                default: state_reg <= S_REQ;
            endcase

            if (flush_i) begin
                fetch_pc_reg <= target_aligned;
            end else if (grant) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end

            if (flush_i) begin
                if_id_reg      <= IF_ID_BUBBLE;
                skid_valid_reg <= 1'b0;
            end else if (stall_i) begin
                if (resp_take) begin
                    skid_valid_reg <= 1'b1;
                    skid_instr_reg <= instr_rdata_i;
                    skid_pc_reg    <= txn_addr_reg;
                end
            end else if (skid_valid_reg) begin
                if_id_reg      <= '{instr: skid_instr_reg, pc: skid_pc_reg,
                                    pc_inc: skid_pc_reg + 32'd4};
                skid_valid_reg <= 1'b0;
            end else if (resp_take) begin
                if_id_reg <= '{instr: instr_rdata_i, pc: txn_addr_reg,
                               pc_inc: txn_addr_reg + 32'd4};
            end else begin
                if_id_reg <= IF_ID_BUBBLE;
            end
        end
    end

`ifdef PANDA_IF_MISALIGNED_TRAP_EN
    logic misaligned_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= flush_i && (branch_target_i[1:0] != 2'b00);
        end
    end

    assign instr_addr_misaligned_o = misaligned_reg;
`endif

endmodule
